// File: rtl/vga_sync_monitor_pkg.sv
// Shared 640x480@60 timing defaults, counter type and lock FSM states for the
// VGA sync monitor.
package vga_sync_monitor_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    localparam int unsigned H_TOTAL_DEF     = 800;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_BP_DEF        = 48;
    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned V_TOTAL_DEF     = 525;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_BP_DEF        = 33;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Counters stick at full scale instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and recovered timing outputs of the VGA sync monitor.
interface vga_sync_monitor_if import vga_sync_monitor_pkg::*;;

    logic pix_en;
    logic hs;
    logic vs;
    cnt_t h_count;
    cnt_t v_count;
    logic bright;
    logic locked;
    cnt_t line_len;
    cnt_t frame_lines;
    logic err;

    modport master (
        output pix_en, hs, vs,
        input  h_count, v_count, bright, locked, line_len, frame_lines, err
    );

    modport slave (
        input  pix_en, hs, vs,
        output h_count, v_count, bright, locked, line_len, frame_lines, err
    );

endinterface

// File: rtl/vga_sync_monitor_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous sync pin plus a registered
// one-clk pulse on the transition to the asserted (SYNC_POL) level.
module sync_edge_detect #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic edge_q;

    // Flops reset to the idle level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ~SYNC_POL;
            sync_q <= ~SYNC_POL;
            prev_q <= ~SYNC_POL;
            edge_q <= 1'b0;
        end else begin
            meta_q <= sync_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            edge_q <= (sync_q == SYNC_POL) && (prev_q != SYNC_POL);
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers pixel coordinates and the active window from external hs/vs,
// measures line/frame lengths and locks once timing matches the parameters.
module vga_sync_monitor import vga_sync_monitor_pkg::*; #(
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input logic               clk,
    input logic               rst_n,
    vga_sync_monitor_if.slave mon
);

    localparam cnt_t       H_TOTAL_C = cnt_t'(H_TOTAL);
    localparam cnt_t       V_TOTAL_C = cnt_t'(V_TOTAL);
    localparam cnt_t       H_ON      = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t       H_OFF     = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam cnt_t       V_ON      = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t       V_OFF     = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [2:0] LOCK_C    = 3'(LOCK_FRAMES);

    logic   hs_edge, vs_edge;
    logic   hs_pend_q, hs_pend_d, vs_pend_q, vs_pend_d;
    cnt_t   h_count_q, h_count_d, v_count_q, v_count_d;
    cnt_t   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic   bright_q, bright_d, err_q, err_d;
    state_e state_q, state_d;
    logic [2:0] good_q, good_d;
    logic   hs_pending, vs_pending, hs_take, frame_end, mismatch;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk(clk), .rst_n(rst_n), .sync_i(mon.hs), .edge_o(hs_edge)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk(clk), .rst_n(rst_n), .sync_i(mon.vs), .edge_o(vs_edge)
    );

    // Edges wait for the next pixel strobe; a vs edge waits for the next taken hs edge.
    always_comb begin
        hs_pending    = hs_pend_q | hs_edge;
        vs_pending    = vs_pend_q | vs_edge;
        hs_take       = mon.pix_en & hs_pending;
        frame_end     = hs_take & vs_pending;
        hs_pend_d     = hs_pending & ~mon.pix_en;
        vs_pend_d     = vs_pending & ~hs_take;
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (hs_take) begin
            line_len_d = sat_inc(h_count_q);
            h_count_d  = '0;
            if (vs_pending) begin
                frame_lines_d = sat_inc(v_count_q);
                v_count_d     = '0;
            end else begin
                v_count_d = sat_inc(v_count_q);
            end
        end else if (mon.pix_en) begin
            h_count_d = sat_inc(h_count_q);
        end
        bright_d = (h_count_d >= H_ON) && (h_count_d < H_OFF) &&
                   (v_count_d >= V_ON) && (v_count_d < V_OFF);
        mismatch = (hs_take && (line_len_d != H_TOTAL_C)) ||
                   (frame_end && (frame_lines_d != V_TOTAL_C)) ||
                   ((h_count_d == CNT_MAX) && (h_count_q != CNT_MAX));
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (frame_end) begin
                    state_d = ST_TRACK;
                    good_d  = '0;
                end
            end
            ST_TRACK: begin
                if (mismatch) begin
                    state_d = ST_SEARCH;
                end else if (frame_end) begin
                    good_d = good_q + 3'd1;
                    if (good_d == LOCK_C) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (mismatch) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        err_d      = mismatch && (state_q != ST_SEARCH);
        mon.locked = (state_q == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            good_q        <= '0;
            hs_pend_q     <= 1'b0;
            vs_pend_q     <= 1'b0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            bright_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            hs_pend_q     <= hs_pend_d;
            vs_pend_q     <= vs_pend_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            bright_q      <= bright_d;
            err_q         <= err_d;
        end
    end

    assign mon.h_count     = h_count_q;
    assign mon.v_count     = v_count_q;
    assign mon.bright      = bright_q;
    assign mon.line_len    = line_len_q;
    assign mon.frame_lines = frame_lines_q;
    assign mon.err         = err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down raster (20x10 pixels),
// running an active-low and an active-high instance from mirrored pins.
module tb_vga_sync_monitor;

    localparam int unsigned H_TOT = 20;
    localparam int unsigned H_SYN = 3;
    localparam int unsigned H_BPC = 2;
    localparam int unsigned H_ACT = 12;
    localparam int unsigned V_TOT = 10;
    localparam int unsigned V_SYN = 2;
    localparam int unsigned V_BPC = 1;
    localparam int unsigned V_ACT = 6;

    logic clk;
    logic rst_n;

    vga_sync_monitor_if bus0 ();
    vga_sync_monitor_if bus1 ();

    vga_sync_monitor #(
        .H_TOTAL(H_TOT), .H_SYNC(H_SYN), .H_BP(H_BPC), .H_ACTIVE(H_ACT),
        .V_TOTAL(V_TOT), .V_SYNC(V_SYN), .V_BP(V_BPC), .V_ACTIVE(V_ACT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .mon(bus0));

    vga_sync_monitor #(
        .H_TOTAL(H_TOT), .H_SYNC(H_SYN), .H_BP(H_BPC), .H_ACTIVE(H_ACT),
        .V_TOTAL(V_TOT), .V_SYNC(V_SYN), .V_BP(V_BPC), .V_ACTIVE(V_ACT),
        .SYNC_POL(1'b1), .LOCK_FRAMES(2)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .mon(bus1));

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned err_pulses = 0;
    int unsigned err_while_locked = 0;
    int unsigned pol_diff = 0;
    int unsigned bright_cnt = 0;
    logic        counting = 1'b0;
    logic        seen_bright = 1'b0;
    int unsigned first_h = 0;
    int unsigned first_v = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.err) err_pulses <= err_pulses + 1;
        if (bus0.err && bus0.locked) err_while_locked <= err_while_locked + 1;
        if ({bus0.h_count, bus0.v_count, bus0.bright, bus0.locked, bus0.line_len,
             bus0.frame_lines, bus0.err} !==
            {bus1.h_count, bus1.v_count, bus1.bright, bus1.locked, bus1.line_len,
             bus1.frame_lines, bus1.err})
            pol_diff <= pol_diff + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel = two clocks with pix_en high in the first; entered and left at posedge+1.
    task automatic pixel(input logic h_act, input logic v_act);
        bus0.hs = ~h_act;
        bus0.vs = ~v_act;
        bus1.hs = h_act;
        bus1.vs = v_act;
        bus0.pix_en = 1'b1;
        bus1.pix_en = 1'b1;
        @(posedge clk); #1;
        bus0.pix_en = 1'b0;
        bus1.pix_en = 1'b0;
        @(posedge clk); #1;
        if (counting && bus0.bright) begin
            if (!seen_bright) begin
                seen_bright = 1'b1;
                first_h = 32'(bus0.h_count);
                first_v = 32'(bus0.v_count);
            end
            bright_cnt++;
        end
    endtask

    task automatic run_line(input int unsigned v, input int unsigned from, input int unsigned to);
        for (int unsigned p = from; p < to; p++) pixel(p < H_SYN, v < V_SYN);
    endtask

    task automatic run_frame(input int unsigned first_px);
        for (int unsigned v = 0; v < V_TOT; v++) run_line(v, (v == 0) ? first_px : 0, H_TOT);
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.pix_en = 1'b0; bus0.hs = 1'b1; bus0.vs = 1'b1;
        bus1.pix_en = 1'b0; bus1.hs = 1'b0; bus1.vs = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_h",      bus0.h_count, 0);
        check("rst_v",      bus0.v_count, 0);
        check("rst_bright", bus0.bright, 0);
        check("rst_locked", bus0.locked, 0);
        check("rst_len",    bus0.line_len, 0);
        check("rst_lines",  bus0.frame_lines, 0);
        check("rst_err",    bus0.err, 0);
        check("rst_h_pol1", bus1.h_count, 0);
        rst_n = 1'b1;

        // Free-running without sync, then asynchronous reset mid-line
        repeat (30) pixel(1'b0, 1'b0);
        check("free_h",      bus0.h_count, 30);
        check("nosync_lock", bus0.locked, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_h0", bus0.h_count, 0);
        check("async_rst_h1", bus1.h_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal timing: lock on the third vs edge
        run_frame(0);
        run_frame(0);
        check("lock_after_2", bus0.locked, 0);
        check("lines_nominal", bus0.frame_lines, V_TOT);
        check("len_nominal",  bus0.line_len, H_TOT);
        run_line(0, 0, 3);
        check("lock_3rd_vs",  bus0.locked, 1);
        check("lock_3rd_vs1", bus1.locked, 1);
        check("same_px_h",    bus0.h_count, 0);
        check("same_px_v",    bus0.v_count, 0);
        check("same_px_v1",   bus1.v_count, 0);
        check("no_err_nom",   err_pulses, 0);

        // Bright window over exactly one frame worth of pixels
        counting = 1'b1;
        run_frame(3);
        run_line(0, 0, 3);
        counting = 1'b0;
        check("bright_cnt",   bright_cnt, H_ACT * V_ACT);
        check("first_br_h",   first_h, H_SYN + H_BPC);
        check("first_br_v",   first_v, V_SYN + V_BPC);

        // Short line while locked
        run_line(0, 3, H_TOT);
        for (int unsigned v = 1; v < 4; v++) run_line(v, 0, H_TOT);
        run_line(4, 0, H_TOT - 1);
        run_line(5, 0, 3);
        check("short_len",    bus0.line_len, H_TOT - 1);
        check("short_unlock", bus0.locked, 0);
        check("short_err",    err_pulses, 1);
        check("err_lock_ovl", err_while_locked, 0);
        run_line(5, 3, H_TOT);
        for (int unsigned v = 6; v < V_TOT; v++) run_line(v, 0, H_TOT);
        run_frame(0);
        run_frame(0);
        check("relock_early", bus0.locked, 0);
        run_line(0, 0, 3);
        check("relock",       bus0.locked, 1);
        check("relock_err",   err_pulses, 1);

        // hs removed while locked: saturation and single timeout error
        repeat (1100) pixel(1'b0, 1'b0);
        check("sat_h0",       bus0.h_count, 1023);
        check("sat_h1",       bus1.h_count, 1023);
        check("tmo_unlock",   bus0.locked, 0);
        check("tmo_err",      err_pulses, 2);
        check("tmo_err_lock", err_while_locked, 0);

        // Sync returns with hs and vs in the same pixel
        run_line(0, 0, 3);
        check("sat_len",      bus0.line_len, 1023);
        check("short_frame",  bus0.frame_lines, 1);
        check("both_h",       bus0.h_count, 0);
        check("both_v",       bus0.v_count, 0);
        check("both_v1",      bus1.v_count, 0);
        check("search_noerr", err_pulses, 2);
        run_frame(3);
        run_line(0, 0, 3);
        check("trk_lines",    bus0.frame_lines, V_TOT);
        check("trk_len",      bus0.line_len, H_TOT);
        check("trk_unlocked", bus0.locked, 0);
        check("trk_err",      err_pulses, 2);
        check("pol_equiv",    pol_diff, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
